// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared-memory port seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding CPU/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_ack_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_ack_o;
  logic              bus_err_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [3:0]        ram_sel_o;
  logic [31:0]       ram_rdata_i;
  logic              ram_ack_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_data_o, if_ack_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output mem_rdata_o, mem_ack_o, bus_err_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o,
    input  ram_rdata_i, ram_ack_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_data_o, if_ack_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  mem_rdata_o, mem_ack_o, bus_err_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o,
    output ram_rdata_i, ram_ack_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and load/store accesses onto one single-port memory.
// Data port has priority; fetch wins after MAX_MEM_STREAK data grants; unacked accesses time out.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int              SW         = (MAX_MEM_STREAK < 1) ? 1 : $clog2(MAX_MEM_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_MEM_STREAK);
  localparam logic [9:0]      TMO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [9:0]        tmo_q, tmo_d;
  logic              owner_mem_q, owner_mem_d;

  logic              ram_ce_q, ram_ce_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [3:0]        ram_sel_q, ram_sel_d;

  logic [31:0]       if_data_q, if_data_d;
  logic              if_ack_q, if_ack_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_ack_q, mem_ack_d;
  logic              bus_err_q, bus_err_d;

  logic              grant_mem;
  logic              finish;
  logic [31:0]       result;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    owner_mem_d = owner_mem_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_sel_d   = ram_sel_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    grant_mem   = 1'b0;
    finish      = 1'b0;
    result      = 32'h0;

    case (state_q)
      S_IDLE: begin
        tmo_d = 10'd0;
        if (!bus.if_req_i) begin
          streak_d = '0;
        end
        if (bus.if_req_i || bus.mem_req_i) begin
          grant_mem = bus.mem_req_i && (!bus.if_req_i || streak_q != STREAK_MAX);
          ram_ce_d  = 1'b1;
          state_d   = S_XFER;
          if (grant_mem) begin
            owner_mem_d = 1'b1;
            ram_we_d    = bus.mem_we_i;
            ram_addr_d  = bus.mem_addr_i;
            ram_wdata_d = bus.mem_wdata_i;
            ram_sel_d   = bus.mem_sel_i;
            if (bus.if_req_i && streak_q != STREAK_MAX) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            owner_mem_d = 1'b0;
            ram_we_d    = 1'b0;
            ram_addr_d  = bus.if_addr_i;
            ram_wdata_d = 32'h0;
            ram_sel_d   = 4'hF;
            streak_d    = '0;
          end
        end
      end

      S_XFER: begin
        // An ack in the final allowed cycle still wins over the abort.
        if (bus.ram_ack_i) begin
          finish = 1'b1;
          result = bus.ram_rdata_i;
        end else if (tmo_q == TMO_LAST) begin
          finish    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
        if (finish) begin
          ram_ce_d = 1'b0;
          state_d  = S_DONE;
          if (owner_mem_q) begin
            mem_rdata_d = result;
            mem_ack_d   = 1'b1;
          end else begin
            if_data_d = result;
            if_ack_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      tmo_q       <= 10'd0;
      owner_mem_q <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      ram_sel_q   <= 4'h0;
      if_data_q   <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= 32'h0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      owner_mem_q <= owner_mem_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      if_data_q   <= if_data_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.ram_ce_o    = ram_ce_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wdata_o = ram_wdata_q;
  assign bus.ram_sel_o   = ram_sel_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and checks port, data, error flag and completion cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (32),
    .MAX_MEM_STREAK(4),
    .TIMEOUT       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          port_mem;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int   lat    = 0;
  bit   noack  = 1'b0;
  bit   stray  = 1'b0;
  int   mem_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00A00093 : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory model: acks in the lat-th cycle of ce, or never when noack is set.
  always @(negedge clk) begin
    if (stray) begin
      bus.ram_ack_i   = 1'b1;
      bus.ram_rdata_i = 32'hBAD0BAD0;
    end else if (bus.ram_ce_o === 1'b1) begin
      if (!noack && mem_cnt == lat) begin
        bus.ram_ack_i   = 1'b1;
        bus.ram_rdata_i = rd_fn(bus.ram_addr_o);
      end else begin
        bus.ram_ack_i = 1'b0;
      end
      mem_cnt++;
    end else begin
      bus.ram_ack_i = 1'b0;
      mem_cnt       = 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_ack_o === 1'b1 || bus.mem_ack_o === 1'b1) begin
      $display("ack cycle=%0d if_ack=%b mem_ack=%b err=%b if_data=%h mem_rdata=%h",
               cyc, bus.if_ack_o, bus.mem_ack_o, bus.bus_err_o, bus.if_data_o, bus.mem_rdata_o);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got an ack, required none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'b0, bus.mem_ack_o}, {31'b0, e.port_mem});
        chk("ack_exclusive", {31'b0, bus.if_ack_o & bus.mem_ack_o}, 32'h0);
        chk("ack_data", e.port_mem ? bus.mem_rdata_o : bus.if_data_o, e.data);
        chk("ack_err", {31'b0, bus.bus_err_o}, {31'b0, e.err});
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (bus.bus_err_o === 1'b1) begin
      total++;
      bad++;
      $display("FAIL lone_bus_err: got bus_err_o=1 without ack, required 0 (cycle %0d)", cyc);
    end
  end

  task automatic push(input bit pm, input logic [31:0] d, input bit err, input int c);
    exp_t e;
    e.port_mem = pm;
    e.data     = d;
    e.err      = err;
    e.cyc      = c;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit pm);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if ((pm ? bus.mem_ack_o : bus.if_ack_o) === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ack_wait: got no ack on port %0d within 60 cycles, required one", pm);
    end
    if (pm) begin
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
    end else begin
      bus.if_req_i = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ce"},    {31'b0, bus.ram_ce_o}, 32'h0);
    chk({tag, "_we"},    {31'b0, bus.ram_we_o}, 32'h0);
    chk({tag, "_addr"},  bus.ram_addr_o, 32'h0);
    chk({tag, "_wdata"}, bus.ram_wdata_o, 32'h0);
    chk({tag, "_sel"},   {28'b0, bus.ram_sel_o}, 32'h0);
    chk({tag, "_ifack"}, {31'b0, bus.if_ack_o}, 32'h0);
    chk({tag, "_mack"},  {31'b0, bus.mem_ack_o}, 32'h0);
    chk({tag, "_err"},   {31'b0, bus.bus_err_o}, 32'h0);
    chk({tag, "_ifd"},   bus.if_data_o, 32'h0);
    chk({tag, "_md"},    bus.mem_rdata_o, 32'h0);
  endtask

  initial begin
    int c;
    int n;
    int n_ack;

    rst             = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = 32'h0;
    bus.mem_wdata_i = 32'h0;
    bus.mem_sel_i   = 4'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single fetch, L=0
    @(negedge clk);
    c = cyc; lat = 0;
    bus.if_addr_i = 32'h10;
    bus.if_req_i  = 1'b1;
    push(1'b0, 32'h00A00093, 1'b0, c + 2);
    @(negedge clk);
    chk("fetch_ce",   {31'b0, bus.ram_ce_o}, 32'h1);
    chk("fetch_we",   {31'b0, bus.ram_we_o}, 32'h0);
    chk("fetch_addr", bus.ram_addr_o, 32'h10);
    chk("fetch_sel",  {28'b0, bus.ram_sel_o}, 32'hF);
    wait_ack(1'b0);

    // Data write, L=3
    @(negedge clk);
    c = cyc; lat = 3;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 32'h100;
    bus.mem_wdata_i = 32'hDEADBEEF;
    bus.mem_sel_i   = 4'b0011;
    bus.mem_req_i   = 1'b1;
    push(1'b1, 32'h5A5A0100, 1'b0, c + 5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_ce",    {31'b0, bus.ram_ce_o}, 32'h1);
      chk("wr_we",    {31'b0, bus.ram_we_o}, 32'h1);
      chk("wr_addr",  bus.ram_addr_o, 32'h100);
      chk("wr_wdata", bus.ram_wdata_o, 32'hDEADBEEF);
      chk("wr_sel",   {28'b0, bus.ram_sel_o}, 32'h3);
    end
    wait_ack(1'b1);

    // Contention: both held, L=0 -> MEM x4 then IF, repeating
    @(negedge clk);
    c = cyc; lat = 0;
    bus.if_addr_i  = 32'h20;
    bus.mem_addr_i = 32'h200;
    bus.mem_sel_i  = 4'hF;
    bus.mem_we_i   = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.mem_req_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push(1'b0, 32'h5A5A0020, 1'b0, c + 2 + 3 * k);
      else            push(1'b1, 32'h5A5A0200, 1'b0, c + 2 + 3 * k);
    end
    n = 0; n_ack = 0;
    while (n_ack < 10 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.if_ack_o === 1'b1 || bus.mem_ack_o === 1'b1) n_ack++;
    end
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
    chk("contention_acks", 32'(n_ack), 32'd10);

    // Timeout on a fetch, then a normal data read
    @(negedge clk);
    c = cyc; noack = 1'b1;
    bus.if_addr_i = 32'h30;
    bus.if_req_i  = 1'b1;
    push(1'b0, 32'h0, 1'b1, c + 9);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("tmo_ce", {31'b0, bus.ram_ce_o}, 32'h1);
    end
    wait_ack(1'b0);
    chk("tmo_ce_off", {31'b0, bus.ram_ce_o}, 32'h0);
    noack = 1'b0;
    @(negedge clk);
    c = cyc; lat = 1;
    bus.mem_addr_i = 32'h200;
    bus.mem_req_i  = 1'b1;
    push(1'b1, 32'h5A5A0200, 1'b0, c + 3);
    wait_ack(1'b1);

    // Reset during XFER with L=5
    @(negedge clk);
    lat = 5;
    bus.mem_addr_i = 32'h300;
    bus.mem_req_i  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    bus.mem_req_i = 1'b0;
    repeat (12) @(negedge clk);
    c = cyc; lat = 0;
    bus.if_addr_i = 32'h10;
    bus.if_req_i  = 1'b1;
    push(1'b0, 32'h00A00093, 1'b0, c + 2);
    wait_ack(1'b0);

    // Stray ack in IDLE
    @(negedge clk);
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ce", {31'b0, bus.ram_ce_o}, 32'h0);
    end
    stray = 1'b0;
    @(negedge clk);
    c = cyc; lat = 2;
    bus.mem_addr_i = 32'h40;
    bus.mem_req_i  = 1'b1;
    push(1'b1, 32'h5A5A0040, 1'b0, c + 4);
    wait_ack(1'b1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit memory between the CPU instruction-fetch port and the CPU load/store port.
- Sits between the cpu and the unified instruction/data memory in the minimal SoPC.
- Serialises accesses, gives the data port priority with an anti-starvation limit for fetch, and aborts accesses the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of all ports.
- MAX_MEM_STREAK, 4, consecutive data-port grants allowed while a fetch is waiting.
- TIMEOUT, 255, cycles to wait for ram_ack_i before aborting. Range 1..1023.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  32  fetched word; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse
- mem_req_i  in  1  data request; held until mem_ack_o
- mem_we_i  in  1  1=write
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  32  write data
- mem_sel_i  in  4  byte enables
- mem_rdata_o  out  32  read data; valid while mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse
- bus_err_o  out  1  one-cycle pulse with the ack of an aborted access
- ram_ce_o  out  1  memory access active
- ram_we_o  out  1  memory write
- ram_addr_o  out  ADDR_W  memory address
- ram_wdata_o  out  32  memory write data
- ram_sel_o  out  4  memory byte enables
- ram_rdata_i  in  32  memory read data; valid with ram_ack_i
- ram_ack_i  in  1  memory completion; 0 or more cycles after ram_ce_o rises

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: every output 0. State IDLE, streak counter 0, timeout counter 0. Asserting rst mid-access abandons it immediately; no ack is issued afterwards.
- All outputs are registered.
- State IDLE: a grant is decided when any request is high.
  - Only one request high: grant it.
  - Both high: grant MEM unless streak == MAX_MEM_STREAK, in which case grant IF.
  - On a grant, at the next edge: latch the granted port's address, command, wdata and sel into ram_*; ram_ce_o=1; go to XFER.
  - IF accesses drive ram_we_o=0 and ram_sel_o=4'hF.
- Streak counter:
  - Increments on each MEM grant made while if_req_i=1.
  - Clears on any IF grant, and whenever if_req_i=0 in IDLE.
  - Saturates at MAX_MEM_STREAK.
- State XFER: ram_* outputs are held stable.
  - Timeout counter counts cycles spent in XFER.
  - ram_ack_i=1: capture ram_rdata_i into the owner's data output; go to DONE; ram_ce_o=0. Writes also present the captured value.
  - Counter reaches TIMEOUT with no ack: go to DONE with the error flag set; data output = 32'h0; ram_ce_o=0.
- State DONE, lasting exactly one cycle:
  - Owner's ack_o=1; bus_err_o=1 if the access was aborted; the other ack stays 0.
  - Next state is IDLE. No grant is made in DONE, so the requester can drop or change its request.
- Latency: request sampled in cycle t.
  - ram_ce_o is high from t+1.
  - With memory ack latency L (ack in cycle t+1+L), ack_o is high in t+2+L.
  - Best-case throughput is one access per 3 cycles.
- Requester protocol: a request must stay stable until its ack. A request dropped before its ack is still completed.
- A stray ram_ack_i outside XFER is ignored.
- if_ack_o and mem_ack_o are never high in the same cycle.
- Data outputs hold their last value outside the ack cycle; they are valid only during ack.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=32'h10, memory acks in its first ce cycle with 32'h00A00093 -> ram_ce_o high 1 cycle after the request; if_ack_o pulse 2 cycles after the request with if_data_o=32'h00A00093.
- Data write, L=3: mem_we_i=1, addr 32'h100, wdata 32'hDEADBEEF, sel 4'b0011 -> ram_* hold these values for 4 cycles; mem_ack_o pulses at t+5; if_ack_o stays 0.
- Contention, MAX_MEM_STREAK=4: both requests held continuously, every access L=0 -> grant order MEM,MEM,MEM,MEM,IF, repeating; fetch is never starved.
- Timeout, TIMEOUT=8: memory never acks a fetch -> ram_ce_o high 8 cycles; if_ack_o and bus_err_o pulse together; if_data_o=0; a subsequent MEM request completes normally.
- Reset mid-access: rst asserted during XFER with L=5 -> next cycle all outputs 0; no ack ever issued for that access; a fresh request after reset is served normally.
- Stray ack: ram_ack_i pulses in IDLE -> no ack output and no state change.
